// File: rtl/display_pkg.sv
// display_pkg: active-low seven-segment patterns, digit-enable codes and the BCD decoder
package display_pkg;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [1:0] AN_UNITS  = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;
    localparam logic [1:0] AN_OFF    = 2'b11;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running 0..SCAN_DIV-1 counter, tick high on the terminal count
module scan_prescaler #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = cnt == W'(SCAN_DIV - 1);

    always_ff @(posedge clk) begin
        cnt <= (rst || tick) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/decade_display_mux.sv
// decade_display_mux: tens counter fed by the decade counter, driving a 2-digit multiplexed display
module decade_display_mux
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count,
    input  logic       ten,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] tens_digit,
    output logic       ovf
);
    logic       ten_q;
    logic       inc;
    logic       tick;
    logic       sel;
    logic       blank;
    logic [6:0] seg_d;
    logic [1:0] an_d;

    scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign inc   = ten & ~ten_q;
    assign blank = BLANK_LZ && tens_digit == 4'd0;

    // tens slot shows the pre-increment value when inc lands in the same cycle
    always_comb begin
        seg_d = !sel ? bcd_to_seg(count) : blank ? SEG_BLANK : bcd_to_seg(tens_digit);
        an_d  = !sel ? AN_UNITS : blank ? AN_OFF : AN_TENS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ten_q      <= 1'b0;
            sel        <= 1'b0;
            tens_digit <= 4'd0;
            ovf        <= 1'b0;
            seg        <= SEG_BLANK;
            an         <= AN_OFF;
        end else begin
            ten_q      <= ten;
            sel        <= sel ^ tick;
            ovf        <= inc && tens_digit == 4'd9;
            tens_digit <= !inc ? tens_digit : (tens_digit == 4'd9) ? 4'd0 : tens_digit + 4'd1;
            seg        <= seg_d;
            an         <= an_d;
        end
    end
endmodule

// File: tb/tb_decade_display_mux.sv
// tb_decade_display_mux: directed and random stimulus checked against a behavioural display model
module tb_decade_display_mux;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count = 4'd0;
    logic       ten = 1'b0;
    logic [6:0] seg0, seg1;
    logic [1:0] an0, an1;
    logic [3:0] tens0, tens1;
    logic       ovf0, ovf1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decade_display_mux #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .count(count), .ten(ten),
        .seg(seg0), .an(an0), .tens_digit(tens0), .ovf(ovf0)
    );

    decade_display_mux #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .count(count), .ten(ten),
        .seg(seg1), .an(an1), .tens_digit(tens1), .ovf(ovf1)
    );

    function automatic logic [6:0] dec(input int v);
        logic [6:0] tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (v >= 0 && v <= 9) ? tab[v] : 7'b0111111;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: elapsed cycles since reset give the slot, rising-edge count mod 10 gives the tens value
    int         k = 0;
    int         edges = 0;
    bit         prev = 1'b0;
    bit         valid = 1'b0;
    int         e_tens = 0;
    bit         e_ovf = 1'b0;
    logic [6:0] e_seg0 = 7'h7f, e_seg1 = 7'h7f;
    logic [1:0] e_an0 = 2'b11, e_an1 = 2'b11;

    always @(posedge clk) begin
        if (rst) begin
            k = 0; edges = 0; prev = 1'b0; valid = 1'b1;
            e_tens = 0; e_ovf = 1'b0;
            e_seg0 = 7'h7f; e_seg1 = 7'h7f; e_an0 = 2'b11; e_an1 = 2'b11;
        end else begin
            if (((k / SD) % 2) == 0) begin
                e_an0 = 2'b10; e_seg0 = dec(int'(count));
                e_an1 = 2'b10; e_seg1 = dec(int'(count));
            end else begin
                e_an0 = 2'b01; e_seg0 = dec(edges % 10);
                e_an1 = (edges % 10 == 0) ? 2'b11 : 2'b01;
                e_seg1 = (edges % 10 == 0) ? 7'h7f : dec(edges % 10);
            end
            e_ovf = 1'b0;
            if (ten && !prev) begin
                edges++;
                e_ovf = (edges % 10 == 0);
            end
            prev = ten;
            k++;
            e_tens = edges % 10;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            chk("seg0", int'(seg0), int'(e_seg0));
            chk("an0", int'(an0), int'(e_an0));
            chk("seg1", int'(seg1), int'(e_seg1));
            chk("an1", int'(an1), int'(e_an1));
            chk("tens", int'(tens0), e_tens);
            chk("tens_b", int'(tens1), e_tens);
            chk("ovf", int'(ovf0), int'(e_ovf));
            chk("ovf_b", int'(ovf1), int'(e_ovf));
        end
    end

    task automatic rst_pulse();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("lit_rst_seg", int'(seg0), 'h7f);
        chk("lit_rst_an", int'(an0), 'b11);
        chk("lit_rst_tens", int'(tens0), 0);
        chk("lit_rst_ovf", int'(ovf0), 0);
        rst = 1'b0;
        count = 4'd3;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("lit_scan_an", int'(an0), (i <= 4) ? 'b10 : 'b01);
            chk("lit_scan_seg", int'(seg0), (i <= 4) ? 'b0110000 : 'b1000000);
        end

        rst_pulse();
        ten = 1'b1;
        @(negedge clk);
        chk("lit_long_first", int'(tens0), 1);
        repeat (4) @(negedge clk);
        ten = 1'b0;
        @(negedge clk);
        chk("lit_long_once", int'(tens0), 1);

        rst_pulse();
        for (int p = 1; p <= 10; p++) begin
            ten = 1'b1;
            @(negedge clk);
            chk("lit_wrap_tens", int'(tens0), p % 10);
            chk("lit_wrap_ovf", int'(ovf0), (p == 10) ? 1 : 0);
            ten = 1'b0;
            @(negedge clk);
            chk("lit_wrap_ovf_low", int'(ovf0), 0);
        end

        rst_pulse();
        count = 4'd7;
        @(negedge clk);
        chk("lit_blank_units", int'(seg1), 'b1111000);
        repeat (4) @(negedge clk);
        chk("lit_blank_an", int'(an1), 'b11);
        chk("lit_blank_seg", int'(seg1), 'h7f);
        ten = 1'b1;
        @(negedge clk);
        ten = 1'b0;
        @(negedge clk);
        chk("lit_blank_one", int'(seg1), 'b1111001);
        chk("lit_blank_one_an", int'(an1), 'b01);
        count = 4'd12;
        repeat (2) @(negedge clk);
        chk("lit_illegal_seg", int'(seg0), 'b0111111);

        rst = 1'b1;
        ten = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ten = 1'b0;
        @(negedge clk);
        chk("lit_ten_rst", int'(tens0), 0);

        for (int c = 0; c < 3000; c++) begin
            count = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ten = ~ten;
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decade_display_mux.md
Name: decade_display_mux

Overview:
- Downstream consumer of the decade counter. Takes its 4-bit units count and its `ten` indication, and keeps a tens digit (0-9).
- Drives a time-multiplexed, 2-digit, active-low seven-segment display: units and tens.
- Sits between the counting stage and the board display pins. Also emits an overflow pulse when 99 rolls to 00.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot. Legal range 2..2^20. The prescaler width is derived with $clog2.
- BLANK_LZ, 1, when 1 the tens digit is blanked while it equals 0.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- count  input  4  units digit from the decade counter. Legal range 0-9.
- ten  input  1  decade indication from the counter. May be a one-cycle pulse or a multi-cycle level.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low, registered.
- an  output  2  digit enables, active low, registered. an[0] = units, an[1] = tens.
- tens_digit  output  4  current tens value, 0-9, registered.
- ovf  output  1  one-cycle pulse when tens wraps 9->0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - tens_digit=0, ovf=0, seg=7'b1111111, an=2'b11.
  - Prescaler=0, slot select sel=0 (units), internal ten_q=0.
  - rst has priority over every other event in the same cycle.
- Edge detect:
  - ten_q <= ten every cycle.
  - inc = ten & ~ten_q.
  - Exactly one increment per rising edge of ten, regardless of pulse length.
- Tens counter, when inc=1:
  - tens_digit < 9: tens_digit+1, ovf=0.
  - tens_digit = 9: tens_digit=0 and ovf=1 for that single cycle.
  - ovf is 0 in every other cycle.
  - Latency: tens_digit updates on the edge after the cycle in which ten first reads high.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and sel toggles.
  - Each digit slot therefore lasts exactly SCAN_DIV cycles.
- Output register (every non-reset cycle):
  - sel=0: an <= 2'b10, seg <= dec(count).
  - sel=1: an <= 2'b01, seg <= dec(tens_digit). Exception: if BLANK_LZ=1 and tens_digit=0, then an <= 2'b11 and seg <= 7'b1111111.
  - Outputs lag sel and the inputs by one cycle.
  - The first cycle after reset release shows units (an=2'b10).
- Decoder dec(), active low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10-15 -> dash 0111111. An illegal count never corrupts tens state.
- Simultaneous events:
  - inc and a slot toggle in the same cycle: both take effect.
  - The tens slot displays the value of tens_digit as registered at the start of that cycle, i.e. before the update (old value for one cycle).
- Reset mid-slot: the display returns to units-first with the prescaler at 0.

Decomposition:
- Shared package `display_pkg`:
  - SEG_* localparams for digits 0-9, SEG_DASH and SEG_BLANK.
  - AN_UNITS / AN_TENS / AN_OFF constants.
  - A pure function `bcd_to_seg(input [3:0])` that returns the active-low pattern.
- One sub-module is natural: `scan_prescaler` (SCAN_DIV parameter; ports clk, rst, tick). It is reused by later display blocks.
- Tens counter and output mux stay in the top.

Test Plan:
- Reset check (SCAN_DIV=4): hold rst 2 cycles -> seg=1111111, an=11, tens_digit=0, ovf=0. The first cycle after release gives an=10.
- Scan timing (SCAN_DIV=4, count=3, tens=0, BLANK_LZ=0) -> an alternates 10/01 every 4 cycles; seg=0110000 in units slots and 1000000 in tens slots.
- Long ten level (ten high 5 cycles) -> tens_digit increments exactly once (0->1), one cycle after ten first reads high.
- Wrap: apply 10 separate ten pulses from tens=0 -> tens_digit goes 1..9 then 0. ovf=1 only in the cycle tens becomes 0.
- Blanking (BLANK_LZ=1, tens=0, count=7) -> tens slot an=11, seg=1111111; units slot seg=1111000. After one ten pulse the tens slot shows 1111001.
- Illegal input count=12 -> units slot seg=0111111. Assert ten together with rst -> tens_digit stays 0.
